// File: rtl/maxpool_window_seq.sv
// maxpool_window_seq: stride-1 K x K "same"-padded max-pool sequencer for the SPPF stage.
// Define MAXPOOL_RELU_EN to clamp each window max at zero (fused ReLU); default passes negatives through.
module maxpool_window_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int K          = 5,
    parameter int DIM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_h,
    input  logic [DIM_WIDTH-1:0]  cfg_w,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DIM_WIDTH-1:0]  out_row,
    output logic [DIM_WIDTH-1:0]  out_col
);
    localparam int TW = $clog2(K);
    localparam int SW = DIM_WIDTH + 2;
    localparam logic [TW-1:0] LAST = TW'(K - 1);
    localparam logic [SW-1:0] HALF = SW'(K / 2);
    localparam logic signed [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, FIN} state_t;

    state_t state, state_nx;
    logic [DIM_WIDTH-1:0] h, w, row, col;
    logic [TW-1:0] tr, tc;
    logic signed [DATA_WIDTH-1:0] acc, tap_val, result;
    logic fold, fold_inb;
    logic [SW-1:0] tap_r, tap_c;
    logic inb, last_tap, col_last, row_last;
    logic [ADDR_WIDTH-1:0] addr;

    // tap coordinates carry two spare bits so that negative offsets show up as a set sign bit
    assign tap_r    = SW'(row) + SW'(tr) - HALF;
    assign tap_c    = SW'(col) + SW'(tc) - HALF;
    assign inb      = !tap_r[SW-1] && tap_r < SW'(h) && !tap_c[SW-1] && tap_c < SW'(w);
    assign addr     = ADDR_WIDTH'(tap_r[DIM_WIDTH-1:0]) * ADDR_WIDTH'(w) + ADDR_WIDTH'(tap_c[DIM_WIDTH-1:0]);
    assign last_tap = tr == LAST && tc == LAST;
    assign col_last = col == w - DIM_WIDTH'(1);
    assign row_last = row == h - DIM_WIDTH'(1);
    assign tap_val  = fold_inb ? $signed(mem_rd_data) : MIN;
`ifdef MAXPOOL_RELU_EN
    assign result   = acc[DATA_WIDTH-1] ? '0 : acc;
`else
    assign result   = acc;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state plus the read and result-stream outputs, all forced to zero outside their states
    always_comb begin
        state_nx    = state;
        mem_rd_en   = state == FETCH && inb;
        mem_rd_addr = mem_rd_en ? addr : '0;
        out_valid   = state == OUT;
        out_data    = out_valid ? result : '0;
        out_row     = out_valid ? row : '0;
        out_col     = out_valid ? col : '0;
        case (state)
            IDLE:    if (start) state_nx = (cfg_h == '0 || cfg_w == '0) ? FIN : FETCH;
            FETCH:   if (last_tap) state_nx = DRAIN;
            DRAIN:   state_nx = OUT;
            OUT:     if (out_ready) state_nx = (row_last && col_last) ? FIN : FETCH;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // config capture, pixel/tap counters, one-cycle-late max fold, registered busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h        <= '0;
            w        <= '0;
            row      <= '0;
            col      <= '0;
            tr       <= '0;
            tc       <= '0;
            acc      <= MIN;
            fold     <= 1'b0;
            fold_inb <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy     <= state == FETCH || state == DRAIN || state == OUT;
            done     <= state == FIN;
            fold     <= state == FETCH;
            fold_inb <= mem_rd_en;
            if (state == IDLE && start) begin
                h   <= cfg_h;
                w   <= cfg_w;
                row <= '0;
                col <= '0;
            end
            if (state == FETCH) begin
                tc <= tc == LAST ? '0 : tc + TW'(1);
                if (tc == LAST) tr <= tr == LAST ? '0 : tr + TW'(1);
            end
            if (state == FETCH && tr == '0 && tc == '0) acc <= MIN;
            else if (fold && tap_val > acc)             acc <= tap_val;
            if (state == OUT && out_ready) begin
                col <= col_last ? '0 : col + DIM_WIDTH'(1);
                if (col_last) row <= row + DIM_WIDTH'(1);
            end
        end
    end
endmodule
